// File: rtl/onchip_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_loader
// Purpose  : Byte-stream loader for the on-chip program/data RAM. Packs an
//            8-bit valid/ready stream little-endian into 32-bit words, writes
//            them at consecutive word addresses from a programmable base and
//            keeps a running mod-2^32 checksum of the written words.
// Optional : LOADER_VERIFY_EN - when defined, the image is re-read after the
//            final write and its masked sum is compared with the checksum.
// Ports    : clk_i, reset_i             clock, synchronous active-high reset
//            start_i, base_addr_i       session start pulse and base address
//            s_data_i/s_valid_i/s_last_i/s_ready_o   byte stream
//            m_address_o, m_byteenable_o, m_chipselect_o, m_write_o,
//            m_writedata_o, m_clken_o, m_readdata_i  Avalon-style RAM master
//            busy_o, done_o, overflow_o, verify_err_o,
//            word_count_o, checksum_o   session status
// Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_loader #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic [ADDR_W-1:0] m_address_o,
  output logic [3:0]        m_byteenable_o,
  output logic              m_chipselect_o,
  output logic              m_write_o,
  output logic [31:0]       m_writedata_o,
  output logic              m_clken_o,
  input  logic [31:0]       m_readdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic              verify_err_o,
  output logic [15:0]       word_count_o,
  output logic [31:0]       checksum_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COLLECT    = 3'd1,
    S_WRITE      = 3'd2,
`ifdef LOADER_VERIFY_EN
    S_VERIFY_RD  = 3'd3,
    S_VERIFY_CMP = 3'd4,
`endif
    S_DONE       = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              last_q, last_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [31:0]       csum_q, csum_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              mcs_q, mcs_d;
  logic              mwr_q, mwr_d;

`ifdef LOADER_VERIFY_EN
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       rd_idx_q, rd_idx_d;
  logic [31:0]       rd_sum_q, rd_sum_d;
  logic              verr_q, verr_d;
  logic [31:0]       lane_mask;
  logic [31:0]       rd_masked;
  logic [31:0]       rd_sum_next;
  logic              rd_final;

  // be_q still holds the final word's lanes: it is only cleared when a new
  // word begins, and the final write leaves the FSM without returning to COLLECT.
  assign lane_mask   = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign rd_final    = (rd_idx_q == (wcnt_q - 16'd1));
  assign rd_masked   = rd_final ? (m_readdata_i & lane_mask) : m_readdata_i;
  assign rd_sum_next = rd_sum_q + rd_masked;
`else
  logic unused_rd;
  assign unused_rd = ^m_readdata_i;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    csum_d  = csum_q;
    ovf_d   = ovf_q;
`ifdef LOADER_VERIFY_EN
    base_d   = base_q;
    rd_idx_d = rd_idx_q;
    rd_sum_d = rd_sum_q;
    verr_d   = verr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_COLLECT;
          addr_d  = base_addr_i;
          lane_d  = 2'd0;
          wdata_d = 32'd0;
          be_d    = 4'd0;
          last_d  = 1'b0;
          wcnt_d  = 16'd0;
          csum_d  = 32'd0;
          ovf_d   = 1'b0;
`ifdef LOADER_VERIFY_EN
          base_d  = base_addr_i;
          verr_d  = 1'b0;
`endif
        end
      end
      S_COLLECT: begin
        if (s_valid_i && ready_q) begin
          wdata_d[{lane_q, 3'b000} +: 8] = s_data_i;
          be_d[lane_q] = 1'b1;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3 || s_last_i) begin
            state_d = S_WRITE;
            last_d  = s_last_i;
          end
        end
      end
      S_WRITE: begin
        wcnt_d = wcnt_q + 16'd1;
        csum_d = csum_q + wdata_q;
        lane_d = 2'd0;
        if (last_q) begin
`ifdef LOADER_VERIFY_EN
          state_d  = S_VERIFY_RD;
          addr_d   = base_q;
          rd_idx_d = 16'd0;
          rd_sum_d = 32'd0;
`else
          state_d  = S_DONE;
`endif
        end else if (addr_q == LAST_ADDR) begin
          // Address saturates at the RAM end; remaining bytes are refused.
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          wdata_d = 32'd0;
          be_d    = 4'd0;
          state_d = S_COLLECT;
        end
      end
`ifdef LOADER_VERIFY_EN
      S_VERIFY_RD: begin
        state_d = S_VERIFY_CMP;
      end
      S_VERIFY_CMP: begin
        if (rd_final) begin
          verr_d  = (rd_sum_next != csum_q);
          state_d = S_DONE;
        end else begin
          rd_sum_d = rd_sum_next;
          rd_idx_d = rd_idx_q + 16'd1;
          addr_d   = addr_q + 1'b1;
          state_d  = S_VERIFY_RD;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs are derived from the next state so they are valid
    // for the whole cycle spent in that state.
    ready_d = (state_d == S_COLLECT);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    mwr_d   = (state_d == S_WRITE);
`ifdef LOADER_VERIFY_EN
    mcs_d   = (state_d == S_WRITE) || (state_d == S_VERIFY_RD);
`else
    mcs_d   = (state_d == S_WRITE);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      last_q  <= 1'b0;
      wcnt_q  <= 16'd0;
      csum_q  <= 32'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      mcs_q   <= 1'b0;
      mwr_q   <= 1'b0;
`ifdef LOADER_VERIFY_EN
      base_q   <= '0;
      rd_idx_q <= 16'd0;
      rd_sum_q <= 32'd0;
      verr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      csum_q  <= csum_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      mcs_q   <= mcs_d;
      mwr_q   <= mwr_d;
`ifdef LOADER_VERIFY_EN
      base_q   <= base_d;
      rd_idx_q <= rd_idx_d;
      rd_sum_q <= rd_sum_d;
      verr_q   <= verr_d;
`endif
    end
  end

  assign s_ready_o      = ready_q;
  assign m_address_o    = addr_q;
  assign m_byteenable_o = be_q;
  assign m_chipselect_o = mcs_q;
  assign m_write_o      = mwr_q;
  assign m_writedata_o  = wdata_q;
  assign m_clken_o      = 1'b1;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign overflow_o     = ovf_q;
  assign word_count_o   = wcnt_q;
  assign checksum_o     = csum_q;
`ifdef LOADER_VERIFY_EN
  assign verify_err_o   = verr_q;
`else
  assign verify_err_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/onchip_mem_loader.md
# onchip_mem_loader

Byte-stream loader that sits directly upstream of the 32 KiW × 32-bit on-chip program/data RAM and drives its Avalon-style slave port. It accepts an 8-bit valid/ready stream (boot UART, JTAG bridge), packs bytes little-endian into 32-bit words and writes them at consecutive word addresses from a programmable base. It keeps a running word checksum. Optionally it re-reads the image and checks that checksum.

## Interface
- ADDR_W, 15, word-address width; matches the RAM's address port.
- DEPTH, 32768, number of RAM words; the last valid address is DEPTH-1.
- clk  in  1  single clock; everything is sampled on its rising edge.
- reset  in  1  synchronous, active-high; returns all state and outputs to their reset values.
- start  in  1  one-cycle pulse that begins a load session; ignored while busy=1.
- base_addr  in  ADDR_W  first word address; sampled on start.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_last  in  1  qualifies the final byte of the image.
- s_ready  out  1  loader accepts a byte this cycle.
- m_address  out  ADDR_W  RAM word address.
- m_byteenable  out  4  RAM byte lanes; bit n enables writedata[8n+7:8n].
- m_chipselect  out  1  RAM access strobe.
- m_write  out  1  write qualifier.
- m_writedata  out  32  packed word.
- m_clken  out  1  RAM clock enable; constant 1 after reset.
- m_readdata  in  32  RAM read data; valid the cycle after a read is presented.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- overflow  out  1  sticky; image exceeded the RAM end.
- verify_err  out  1  sticky; readback checksum mismatch.
- word_count  out  16  words written in the current/last session.
- checksum  out  32  mod-2^32 sum of written words, with disabled lanes counted as zero.

## Operation
- Reset values: all outputs 0 except m_clken=1. FSM state is IDLE. Address and byte lane index are 0.
- IDLE → COLLECT on start. Entering COLLECT:
  - latch base_addr;
  - clear word_count, checksum, overflow and verify_err;
  - set busy=1.
- COLLECT:
  - s_ready=1.
  - An accepted byte (s_valid & s_ready) goes to lane k = byte index mod 4.
  - Move to WRITE after the 4th byte is accepted, or after a byte accepted with s_last=1.
- WRITE: exactly one cycle.
  - m_chipselect=m_write=1.
  - m_byteenable = 1111, or 0001/0011/0111 for a partial final word.
  - Unfilled writedata lanes are 0. s_ready=0.
  - On exit: word_count+1; checksum += writedata.
- After WRITE:
  - If s_last was seen: go to VERIFY (when compiled) or DONE.
  - Otherwise, if the address was DEPTH-1: set overflow=1 and go to DONE; the address never wraps.
  - Otherwise: address+1 and go back to COLLECT.
- DONE: done=1 and busy=0 for one cycle, then IDLE. s_ready stays 0 until the next start.
- Lane packing restarts at lane 0 for every word.
- A start pulse with no bytes following leaves the loader waiting in COLLECT indefinitely.
- A reset asserted at any point aborts the session immediately. No further RAM strobes are issued in the cycle after reset is sampled.

## Timing
- Outputs to the RAM are registered. In WRITE, all m_* signals are stable for the full cycle.
- Throughput: 4 bytes per 5 cycles with s_valid held high.
- Latency from the accepted last byte to the write: 1 cycle. From the write to done (no verify): 1 cycle.
- Read in VERIFY:
  - address is presented with m_chipselect=1 and m_write=0 in cycle t;
  - m_readdata is sampled in cycle t+1;
  - one outstanding read at a time.

## Configuration
- LOADER_VERIFY_EN compiled in: after the final write the FSM runs VERIFY_RD/VERIFY_CMP.
  - It reads word_count words from base_addr, 2 cycles per word.
  - The final word is masked with the stored last byteenable.
  - It sums the masked readback and compares with checksum. A mismatch sets verify_err. Then DONE.
- Not defined: the VERIFY states are absent, verify_err is tied to 0, and the RAM is never read.

## Test plan
- start, base 0x0010, bytes 01..08 back-to-back, last on 08 → writes 0x04030201@0x0010 be 1111 and 0x08070605@0x0011 be 1111; word_count=2; checksum=0x0C0A0806; one done pulse.
- Bytes 01..05, last on 05 → second write 0x00000005@base+1 be 0001; word_count=2.
- Same 8 bytes with s_valid toggling every other cycle → identical writes; s_ready=0 in every WRITE cycle.
- base 0x7FFF, 8 bytes without last → single write at 0x7FFF; overflow=1; done; s_ready=0 afterwards.
- reset asserted after the 6th byte → next cycle all outputs at reset values and no write strobe; a new session then loads correctly.
- LOADER_VERIFY_EN with a RAM model corrupting word 1 → verify_err=1 at done. With an uncorrupted model → verify_err=0.
